// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector with KMP-style failure transitions,
// optional overlapping matches, enable stalls, synchronous clear and a saturating match counter.
module moore_seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         x,
  output logic                         z,
  output logic [$clog2(PAT_LEN+1)-1:0] state_o,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int SW = $clog2(PAT_LEN+1);
  localparam logic [SW-1:0] S0      = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(PAT_LEN);

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic bit pat_bit(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits followed by b).
  function automatic int delta(input int k, input bit b);
    int  res;
    bit  ok;
    int  p;
    bit  c;
    res = 0;
    for (int l = k + 1; l > 0; l--) begin
      if (res == 0) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          p = k + 1 - l + j;
          c = (p < k) ? pat_bit(p) : b;
          if (c != pat_bit(j)) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  // Longest proper suffix of PATTERN that is also a prefix.
  function automatic int border_len(input int n);
    int res;
    bit ok;
    res = 0;
    for (int l = n - 1; l > 0; l--) begin
      if (res == 0) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (pat_bit(n - l + j) != pat_bit(j)) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  localparam int BORDER = border_len(PAT_LEN);

  logic [1:0][SW-1:0] nxt_tbl [PAT_LEN+1];

  // Entry PAT_LEN covers leaving MATCH: restart from the border or from empty history.
  for (genvar g = 0; g <= PAT_LEN; g++) begin : g_tbl
    localparam int KEFF = (g < PAT_LEN) ? g : (OVERLAP ? BORDER : 0);
    localparam int N0   = delta(KEFF, 1'b0);
    localparam int N1   = delta(KEFF, 1'b1);
    assign nxt_tbl[g][0] = SW'(N0);
    assign nxt_tbl[g][1] = SW'(N1);
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat;

  assign sat = &cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = S0;
      cnt_d   = '0;
    end else if (state_q > S_MATCH) begin
      state_d = S0;
    end else if (en) begin
      state_d = nxt_tbl[state_q][x];
      if ((state_d == S_MATCH) && !sat) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z         = (state_q == S_MATCH);
  assign state_o   = state_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: overlapping, non-overlapping and
// narrow-counter instances share one stimulus stream.
module tb_moore_seq_detector;

  logic clk, rst, en, clr, x;

  logic       z_a, z_b, z_c;
  logic [2:0] st_a, st_b, st_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  int n_chk  = 0;
  int n_fail = 0;

  moore_seq_detector u_ovl (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .z(z_a), .state_o(st_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  moore_seq_detector #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .z(z_b), .state_o(st_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  moore_seq_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .z(z_c), .state_o(st_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic xv, input logic ev, input logic cv);
    @(negedge clk);
    x   = xv;
    en  = ev;
    clr = cv;
    @(posedge clk);
    #1;
  endtask

  int fail_bits [6] = '{1, 1, 1, 1, 0, 1};
  int fail_st   [6] = '{1, 2, 2, 2, 3, 4};
  int ovl_bits  [7] = '{1, 1, 0, 1, 1, 0, 1};
  int pat_bits  [4] = '{1, 1, 0, 1};

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0;
    #12;
    chk("reset_z", z_a, 0);
    chk("reset_state", st_a, 0);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_sat", sat_a, 0);
    @(negedge clk);
    rst = 1'b1;

    // basic 1101
    step(1, 1, 0); chk("basic_st1", st_a, 1);
    step(1, 1, 0); chk("basic_st2", st_a, 2);
    step(0, 1, 0); chk("basic_st3", st_a, 3); chk("basic_z_pre", z_a, 0);
    step(1, 1, 0); chk("basic_st4", st_a, 4); chk("basic_z", z_a, 1); chk("basic_cnt", cnt_a, 1);
    step(0, 0, 0); chk("hold_z", z_a, 1); chk("hold_cnt", cnt_a, 1);
    step(0, 1, 0); chk("basic_z_fall", z_a, 0); chk("basic_st_after", st_a, 0);
    chk("basic_nov_st", st_b, 0);

    // failure path 111101
    step(0, 1, 1); chk("clr_cnt", cnt_a, 0);
    for (int i = 0; i < 6; i++) begin
      step(fail_bits[i][0], 1, 0);
      chk($sformatf("fail_st%0d", i), st_a, fail_st[i]);
      if (i == 4) chk("fail_cnt_pre", cnt_a, 0);
    end
    chk("fail_cnt", cnt_a, 1);
    chk("fail_z", z_a, 1);

    // overlap 1101101
    step(0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step(ovl_bits[i][0], 1, 0);
      if (i == 3) chk("ovl_cnt_first", cnt_a, 1);
    end
    chk("ovl_cnt", cnt_a, 2);
    chk("ovl_z", z_a, 1);
    chk("nov_cnt", cnt_b, 1);
    chk("nov_st", st_b, 1);
    chk("nov_z", z_b, 0);
    chk("narrow_cnt", cnt_c, 2);

    // asynchronous reset while z is high
    #1 rst = 1'b0;
    #1;
    chk("async_z", z_a, 0);
    chk("async_cnt", cnt_a, 0);
    chk("async_st", st_a, 0);
    chk("async_nov_cnt", cnt_b, 0);
    @(negedge clk);
    rst = 1'b1;

    // stall
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0); chk("stall_st", st_a, 2);
    step(0, 1, 0);
    step(1, 1, 0); chk("stall_cnt", cnt_a, 1); chk("stall_z", z_a, 1);

    // clear between the halves
    step(0, 1, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1); chk("clr_st", st_a, 0); chk("clr_cnt2", cnt_a, 0);
    step(0, 1, 0);
    step(1, 1, 0); chk("clr_no_match", cnt_a, 0); chk("clr_st_after", st_a, 1);

    // clear on the edge that would complete a match
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0); chk("clr_edge_pre", st_a, 3);
    step(1, 1, 1); chk("clr_edge_st", st_a, 0); chk("clr_edge_cnt", cnt_a, 0);
    chk("clr_edge_z", z_a, 0);

    // saturation on the 2-bit counter
    step(0, 1, 1);
    for (int m = 1; m <= 6; m++) begin
      for (int i = 0; i < 4; i++) step(pat_bits[i][0], 1, 0);
      chk($sformatf("sat_cnt%0d", m), cnt_c, (m < 3) ? m : 3);
      chk($sformatf("sat_flag%0d", m), sat_c, (m >= 3) ? 1 : 0);
      chk($sformatf("wide_cnt%0d", m), cnt_a, m);
    end
    chk("wide_sat", sat_a, 0);
    step(0, 1, 1);
    chk("sat_clr_cnt", cnt_c, 0);
    chk("sat_clr_flag", sat_c, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore-style serial pattern detector; successor to the fixed-pattern single-bit Moore FSM.
- Samples one serial bit per enabled clock and asserts a registered match flag when the last PAT_LEN accepted bits equal PATTERN.
- Adds the following, which the earlier FSM lacks:
  - arbitrary pattern length and value;
  - overlapping and non-overlapping detection modes;
  - input-enable stalls;
  - synchronous clear;
  - saturating match counter.
- Sits between a serial data source and control/status logic.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, PAT_LEN-bit pattern; MSB is the first bit received.
- OVERLAP, 1, 1 = matches may share bits, 0 = detector restarts from empty after each match.
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  sample-enable; x consumed only when en=1.
- clr  input  1  synchronous clear of state, z and match_cnt; has priority over en.
- x  input  1  serial data bit.
- z  output  1  Moore match flag; a function of the current state only.
- state_o  output  $clog2(PAT_LEN+1)  current matched-prefix length (debug).
- match_cnt  output  CNT_W  number of matches since reset/clr; saturating.
- cnt_sat  output  1  high while match_cnt = all ones.

Behaviour:
- State encoding:
  - States S0..S(PAT_LEN-1) hold the matched-prefix length k: the longest suffix of accepted history that equals the first k bits of PATTERN.
  - MATCH is a distinct state; z=1 only in MATCH.
  - state_o reports PAT_LEN in MATCH.
- Reset (rst=0, asynchronous):
  - state=S0, z=0, match_cnt=0, cnt_sat=0, immediately and independent of clk.
  - Deassertion is taken at the next rising edge; no sampling occurs while rst=0.
- clr=1 at a rising edge: same values as reset, regardless of en or x.
- en=0, clr=0: state, z and match_cnt hold. A held MATCH keeps z=1.
- en=1, clr=0, from state Sk:
  - If x equals PATTERN bit k (counting from MSB), go to S(k+1), or to MATCH when k+1 = PAT_LEN.
  - Otherwise go to the failure state: the longest proper prefix of PATTERN that is a suffix of (matched prefix followed by x). This is KMP semantics and must be correct for every legal PATTERN.
  - The failure table is computed at elaboration, not hand-coded.
- en=1, clr=0, from MATCH:
  - OVERLAP=1: continue from the longest proper suffix of PATTERN that is also a prefix, then apply x as above. Back-to-back MATCH is possible only if PATTERN permits it.
  - OVERLAP=0: history is discarded; apply x from S0.
- Latency: z rises in the cycle after the edge that samples the final pattern bit (one-cycle Moore latency). z stays high until the next enabled edge.
- Counter:
  - match_cnt increments by 1 on each transition into MATCH, including MATCH->MATCH.
  - It saturates at 2^CNT_W-1 with no wrap.
  - cnt_sat is a combinational compare of match_cnt.
- Simultaneous events: rst dominates clr, clr dominates en; no increment on a clr edge.
- No X propagation: an illegal state encoding recovers to S0 on the next edge.

Test Plan (defaults unless stated; one x per enabled cycle):
- Reset: hold rst=0 mid-stream with z=1 -> z=0, match_cnt=0, state_o=0 asynchronously, before the next clk edge.
- Basic: x=1,1,0,1 -> z=1 in the cycle after the 4th edge, match_cnt=1; next bit x=0 -> z=0.
- Failure path: x=1,1,1,1,0,1 -> state_o=1,2,2,2,3, then MATCH; exactly one match, after the 6th bit.
- Overlap: x=1,1,0,1,1,0,1 -> OVERLAP=1 gives match_cnt=2 (matches after bits 4 and 7); OVERLAP=0 gives match_cnt=1.
- Stall/clear: x=1,1 with en=1, then 3 cycles en=0 (x=0), then x=0,1 with en=1 -> match_cnt=1. Repeat with clr=1 asserted between the two halves -> no match, state_o=0 after clr.
- Saturation: CNT_W=2, six matches -> match_cnt=3, cnt_sat=1 after the third match, no wrap; clr -> match_cnt=0, cnt_sat=0.
